// File: rtl/irq_pkg.sv
// Shared types and vector-select encodings for the interrupt controller.
package irq_pkg;

  typedef enum logic [1:0] {
    RST_PEND = 2'b00,
    RUN      = 2'b01,
    SERVICE  = 2'b10,
    WAIT     = 2'b11
  } irq_state_t;

  localparam logic [1:0] VEC_NMI = 2'b01;
  localparam logic [1:0] VEC_RST = 2'b10;
  localparam logic [1:0] VEC_IRQ = 2'b11;

endpackage

// File: rtl/pin_sync.sv
// Multi-flop synchroniser for an asynchronous active-low pin; preloads to the
// inactive level (1) on reset.
module pin_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] chain_r;

  // Shift the pin sample through the synchroniser chain.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      chain_r <= {SYNC_STAGES{1'b1}};
    end else begin
      chain_r <= {chain_r[SYNC_STAGES-2:0], d};
    end
  end

  assign q = chain_r[SYNC_STAGES-1];

endmodule

// File: rtl/irq_ctl.sv
// Interrupt controller: pin synchronisation, NMI edge latch, and the
// RST_PEND/RUN/SERVICE/WAIT sequencer that steers the control unit.
module irq_ctl
  import irq_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       nmi_n,
  input  logic       irq_n,
  input  logic       sync,
  input  logic       I,
  input  logic       wai,
  input  logic       vec_ack,
  output logic       take,
  output logic [1:0] vec_sel,
  output logic       rdy,
  output logic       nmi_pend
);

  logic             nmi_s;
  logic             irq_s;
  logic             nmi_prev_r;
  logic [SYNC_STAGES:0] armed_r;
  logic             nmi_pend_r;
  logic             nmi_edge;
  logic             nmi_clear;
  logic             irq_lvl;
  logic             irq_event;
  irq_state_t       state_r;
  irq_state_t       state_nx;
  logic [1:0]       vec_r;
  logic [1:0]       vec_nx;

  pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_nmi_sync (
    .clk   (clk),
    .reset (reset),
    .d     (nmi_n),
    .q     (nmi_s)
  );

  pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_irq_sync (
    .clk   (clk),
    .reset (reset),
    .d     (irq_n),
    .q     (irq_s)
  );

  // Edges only count once both compared samples came from the real pin,
  // so the preloaded 1s cannot fake a falling edge after reset.
  assign nmi_edge  = armed_r[SYNC_STAGES] & nmi_prev_r & ~nmi_s;
  assign irq_lvl   = ~irq_s;
  assign irq_event = nmi_pend_r | (irq_lvl & ~I);
  assign nmi_pend  = nmi_pend_r;

  // State, captured vector, NMI latch and synchroniser-flush tracking.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= RST_PEND;
      vec_r      <= VEC_RST;
      nmi_pend_r <= 1'b0;
      nmi_prev_r <= 1'b1;
      armed_r    <= {(SYNC_STAGES+1){1'b0}};
    end else begin
      state_r    <= state_nx;
      vec_r      <= vec_nx;
      nmi_pend_r <= nmi_edge | (nmi_pend_r & ~nmi_clear);
      nmi_prev_r <= nmi_s;
      armed_r    <= {armed_r[SYNC_STAGES-1:0], 1'b1};
    end
  end

  // Next-state and output decode.
  always_comb begin
    state_nx  = state_r;
    vec_nx    = vec_r;
    take      = 1'b0;
    vec_sel   = VEC_IRQ;
    rdy       = 1'b1;
    nmi_clear = 1'b0;
    case (state_r)
      RST_PEND: begin
        take    = 1'b1;
        vec_sel = VEC_RST;
        if (vec_ack) begin
          state_nx = RUN;
        end else begin
          state_nx = RST_PEND;
        end
      end
      RUN: begin
        vec_sel = nmi_pend_r ? VEC_NMI : VEC_IRQ;
        take    = sync & irq_event;
        if (take) begin
          state_nx  = SERVICE;
          vec_nx    = vec_sel;
          nmi_clear = nmi_pend_r;
        end else if (wai) begin
          state_nx = WAIT;
        end else begin
          state_nx = RUN;
        end
      end
      SERVICE: begin
        vec_sel = vec_r;
        if (vec_ack) begin
          state_nx = RUN;
        end else begin
          state_nx = SERVICE;
        end
      end
      WAIT: begin
        rdy     = 1'b0;
        vec_sel = nmi_pend_r ? VEC_NMI : VEC_IRQ;
        // Wake-up ignores the I flag.
        if (nmi_pend_r | irq_lvl) begin
          state_nx = RUN;
        end else begin
          state_nx = WAIT;
        end
      end
      default: begin
        state_nx = RST_PEND;
        take     = 1'b1;
        vec_sel  = VEC_RST;
      end
    endcase
  end

endmodule

// File: doc/irq_ctl.md
IRQ_CTL -- requirements
Module: irq_ctl

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, meaning the number of flops in each pin synchroniser (legal range 2..3).
REQ-002 SHALL have port clk, input, 1 bit: the single core clock, with all state updating on the rising edge.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port nmi_n, input, 1 bit: asynchronous NMI pin, active-low, falling-edge sensitive.
REQ-005 SHALL have port irq_n, input, 1 bit: asynchronous IRQ pin, active-low, level sensitive.
REQ-006 SHALL have port sync, input, 1 bit: from the control unit; high in the cycle in which the next opcode is decoded.
REQ-007 SHALL have port I, input, 1 bit: the processor interrupt-disable flag.
REQ-008 SHALL have port wai, input, 1 bit: one-cycle pulse issued while the WAI instruction executes.
REQ-009 SHALL have port vec_ack, input, 1 bit: one-cycle pulse issued when the microcode has fetched the vector high byte.
REQ-010 SHALL have port take, output, 1 bit: request to the control unit to enter the interrupt sequence instead of decoding an opcode.
REQ-011 SHALL have port vec_sel, output, 2 bits: vector select, 01 = FFFA (NMI), 10 = FFFC (RST), 11 = FFFE (IRQ).
REQ-012 SHALL have port rdy, output, 1 bit: low while the core is halted by WAI.
REQ-013 SHALL have port nmi_pend, output, 1 bit: status of the latched NMI edge.

Function
REQ-014 SHALL synchronise nmi_n and irq_n through SYNC_STAGES flops each before any use.
REQ-015 SHALL set nmi_pend on a synchronised 1->0 transition of nmi_n, with the flag visible 1 cycle after the last synchroniser stage.
REQ-016 SHALL define irq_lvl as the synchronised value of ~irq_n, which is not latched.
REQ-017 SHALL implement exactly four states: RST_PEND, RUN, SERVICE and WAIT.
REQ-018 SHALL, in RST_PEND, drive take=1 and vec_sel=10, and move to RUN on vec_ack.
REQ-019 SHALL, in RUN, define event = nmi_pend | (irq_lvl & ~I), and drive take = sync & event combinationally from registered state and registered flags.
REQ-020 SHALL, in RUN, drive vec_sel = 01 when nmi_pend, else 11, giving NMI priority over IRQ.
REQ-021 SHALL, on a cycle with take=1 in RUN, capture vec_sel, enter SERVICE, and clear nmi_pend if NMI was selected.
REQ-022 SHALL keep nmi_pend set when a new NMI edge arrives in the same cycle as the clear.
REQ-023 SHALL, in SERVICE, drive take=0, hold the captured vec_sel, and return to RUN on vec_ack.
REQ-024 SHALL latch an NMI edge that occurs during SERVICE, so that it is taken at the next sync in RUN.
REQ-025 SHALL, in RUN with wai=1 and take=0, enter WAIT; if take=1 in the same cycle, take SHALL win and WAIT SHALL NOT be entered.
REQ-026 SHALL, in WAIT, drive rdy=0 and take=0, and return to RUN when nmi_pend=1 or irq_lvl=1, irrespective of I.
REQ-027 SHALL assert rdy=1 in the cycle after leaving WAIT.
REQ-028 SHALL ignore vec_ack in RUN and WAIT, and ignore wai outside RUN.
REQ-029 SHALL drive rdy=1 in every state except WAIT.

Reset
REQ-030 SHALL, on assertion of reset at any time, immediately force state=RST_PEND, nmi_pend=0, all synchroniser flops to 1 (pins inactive), take=1, vec_sel=10 and rdy=1.
REQ-031 SHALL treat a reset asserted mid-SERVICE or mid-WAIT as overriding, and discard any pending NMI.
REQ-032 SHALL NOT detect an NMI edge caused by the synchroniser preload on reset release.

Structure
REQ-033 SHALL place the state enum and the vector-select constants VEC_NMI, VEC_RST and VEC_IRQ in the shared package irq_pkg.
REQ-034 SHALL instantiate a synchroniser sub-module pin_sync, parameterised by SYNC_STAGES, twice.
REQ-035 SHALL have a total RTL size of no more than 200 lines.

Verification
REQ-036 Release reset -> take=1 and vec_sel=10 until vec_ack, then state RUN with take=0.
REQ-037 Hold irq_n=0 with I=1 and sync pulses -> take stays 0; set I=0 -> take=1 and vec_sel=11 on the next sync cycle.
REQ-038 Drive an nmi_n falling edge with irq_n=0 and I=0, then sync -> vec_sel=01, nmi_pend clears, and IRQ is taken on the sync after vec_ack.
REQ-039 Drive a second nmi_n edge during SERVICE -> nmi_pend=1 after vec_ack, and take=1 with vec_sel=01 at the next sync.
REQ-040 Pulse wai, then drive irq_n=0 with I=1 -> rdy=0 until irq_lvl, rdy=1 on the following cycle, and take stays 0.
REQ-041 Assert reset during WAIT with nmi_pend=1 -> same cycle: state RST_PEND, nmi_pend=0, rdy=1, take=1.
